// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller with burst line fill
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cache_ready_out          lookup accepted this cycle
//   cache_valid_in           fetch address valid
//   cache_addr_in[AW]        byte address {tag, index, word offset, byte offset}
//   cache_ready_in           consumer takes a byte this cycle
//   cache_valid_out          cache_data_out holds a fetched byte
//   cache_data_out[8]        fetched byte, byte 0 = data[31:24]
//   memory_stb               word request to memory during a line fill
//   memory_addr[AW-2]        word address {tag_buf, index_buf, word_cnt}
//   memory_data[32]          read word, valid with memory_ack
//   memory_ack               word delivered this cycle
//   flush                    runtime invalidation request (ICACHE_FLUSH_EN only)
//
// Build option: define ICACHE_FLUSH_EN to add the flush port.
module icache_ctrl #(
    parameter int AW        = 16,
    parameter int IDX_BITS  = 6,
    parameter int WOFF_BITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          cache_ready_out,
    input  logic          cache_valid_in,
    input  logic [AW-1:0] cache_addr_in,
    input  logic          cache_ready_in,
    output logic          cache_valid_out,
    output logic [7:0]    cache_data_out,
    output logic          memory_stb,
    output logic [AW-3:0] memory_addr,
    input  logic [31:0]   memory_data,
    input  logic          memory_ack
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic          flush
`endif
);

    localparam int TAG_BITS = AW - IDX_BITS - WOFF_BITS - 2;
    localparam int LINES    = 1 << IDX_BITS;
    localparam int WORDS    = 1 << (IDX_BITS + WOFF_BITS);

    typedef enum logic [1:0] {INVAL, RUN, FILL, REREAD} state_t;

    state_t state_q, state_d;

    logic [TAG_BITS-1:0]  tag_buf;
    logic [IDX_BITS-1:0]  idx_buf;
    logic [WOFF_BITS-1:0] woff_buf;
    logic [1:0]           boff_buf;
    logic                 valid_buf;

    logic [IDX_BITS-1:0]  inv_cnt;
    logic [WOFF_BITS-1:0] word_cnt;
    logic                 flush_pend;
    logic                 flush_start;

    logic                 line_valid_q;
    logic [TAG_BITS-1:0]  line_tag_q;
    logic [31:0]          line_data_q;

    logic                 valid_mem [LINES];
    logic [TAG_BITS-1:0]  tag_mem   [LINES];
    logic [31:0]          data_mem  [WORDS];

    logic [TAG_BITS-1:0]  a_tag;
    logic [IDX_BITS-1:0]  a_idx;
    logic [WOFF_BITS-1:0] a_woff;
    logic                 hit;
    logic                 last_word;
    logic                 last_line;

    assign a_tag  = cache_addr_in[AW-1 -: TAG_BITS];
    assign a_idx  = cache_addr_in[WOFF_BITS+2 +: IDX_BITS];
    assign a_woff = cache_addr_in[2 +: WOFF_BITS];

    assign hit       = line_valid_q & (line_tag_q == tag_buf);
    assign last_word = (word_cnt == {WOFF_BITS{1'b1}});
    assign last_line = (inv_cnt == {IDX_BITS{1'b1}});

    assign cache_valid_out = valid_buf & hit & (state_q == RUN);
    assign memory_addr     = {tag_buf, idx_buf, word_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INVAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cache_ready_out = 1'b0;
        memory_stb      = 1'b0;
        flush_start     = 1'b0;
        case (state_q)
            INVAL: begin
                if (last_line) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cache_ready_out = cache_ready_in & (hit | ~valid_buf) & ~flush_pend;
                if (valid_buf & ~hit) begin
                    state_d = FILL;
                end else if (flush_pend & ~valid_buf) begin
                    state_d     = INVAL;
                    flush_start = 1'b1;
                end
            end
            FILL: begin
                memory_stb = 1'b1;
                if (memory_ack && last_word) begin
                    state_d = REREAD;
                end
            end
            REREAD: begin
                state_d = RUN;
            end
            default: begin
                state_d = INVAL;
            end
        endcase
    end

    // Lookup buffers and array output registers. The array outputs only
    // move on an accepted lookup or on the post-fill re-read, so a stalled
    // consumer sees a frozen byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_buf    <= 1'b0;
            tag_buf      <= '0;
            idx_buf      <= '0;
            woff_buf     <= '0;
            boff_buf     <= '0;
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            line_data_q  <= '0;
        end else begin
            if (cache_ready_out) begin
                valid_buf    <= cache_valid_in;
                tag_buf      <= a_tag;
                idx_buf      <= a_idx;
                woff_buf     <= a_woff;
                boff_buf     <= cache_addr_in[1:0];
                line_valid_q <= valid_mem[a_idx];
                line_tag_q   <= tag_mem[a_idx];
                line_data_q  <= data_mem[{a_idx, a_woff}];
            end else if (state_q == REREAD) begin
                line_valid_q <= valid_mem[idx_buf];
                line_tag_q   <= tag_mem[idx_buf];
                line_data_q  <= data_mem[{idx_buf, woff_buf}];
            end else if (flush_pend && cache_valid_out && cache_ready_in) begin
                // Lookups are blocked while a flush waits, so the last
                // delivered byte has to retire its own valid_buf.
                valid_buf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (state_q == INVAL) begin
                inv_cnt <= inv_cnt + 1'b1;
            end else if (flush_start) begin
                inv_cnt <= '0;
            end
            if (state_q == RUN && state_d == FILL) begin
                word_cnt <= '0;
            end else if (state_q == FILL && memory_ack) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

`ifdef ICACHE_FLUSH_EN
    // A flush seen during a sweep is dropped: the sweep already clears
    // everything it would have cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else if (flush_start) begin
            flush_pend <= 1'b0;
        end else if (flush && state_q != INVAL) begin
            flush_pend <= 1'b1;
        end
    end
`else
    assign flush_pend = 1'b0;
`endif

    // Arrays carry no reset; the INVAL sweep makes their contents harmless.
    // Sweep writes and fill writes live in different states, so they never
    // collide on valid_mem.
    always_ff @(posedge clk) begin
        if (state_q == INVAL) begin
            valid_mem[inv_cnt] <= 1'b0;
        end
        if (state_q == FILL && memory_ack) begin
            data_mem[{idx_buf, word_cnt}] <= memory_data;
            if (last_word) begin
                tag_mem[idx_buf]   <= tag_buf;
                valid_mem[idx_buf] <= 1'b1;
            end
        end
    end

    always_comb begin
        cache_data_out = line_data_q[31:24];
        case (boff_buf)
            2'd0: cache_data_out = line_data_q[31:24];
            2'd1: cache_data_out = line_data_q[23:16];
            2'd2: cache_data_out = line_data_q[15:8];
            2'd3: cache_data_out = line_data_q[7:0];
            default: cache_data_out = line_data_q[31:24];
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - self-checking bench for icache_ctrl
module tb_icache_ctrl;

    logic        clk;
    logic        rst;
    logic        cache_ready_out;
    logic        cache_valid_in;
    logic [15:0] cache_addr_in;
    logic        cache_ready_in;
    logic        cache_valid_out;
    logic [7:0]  cache_data_out;
    logic        memory_stb;
    logic [13:0] memory_addr;
    logic [31:0] memory_data;
    logic        memory_ack;
`ifdef ICACHE_FLUSH_EN
    logic        flush;
`endif

    icache_ctrl #(.AW(16), .IDX_BITS(6), .WOFF_BITS(2)) dut (
        .clk(clk),
        .rst(rst),
        .cache_ready_out(cache_ready_out),
        .cache_valid_in(cache_valid_in),
        .cache_addr_in(cache_addr_in),
        .cache_ready_in(cache_ready_in),
        .cache_valid_out(cache_valid_out),
        .cache_data_out(cache_data_out),
        .memory_stb(memory_stb),
        .memory_addr(memory_addr),
        .memory_data(memory_data),
        .memory_ack(memory_ack)
`ifdef ICACHE_FLUSH_EN
        ,
        .flush(flush)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [13:0] exp_maddr[$];
    logic        m_valid [64];
    logic [5:0]  m_tag   [64];

    int          ack_count = 0;
    int          ack_stop  = -1;
    bit          gap_mode  = 1'b0;
    bit          skip      = 1'b0;
    logic        stb_prev  = 1'b0;
    logic [13:0] addr_prev = '0;
    int          ncyc      = 0;
    int          run_len   = 0;
    int          max_run   = 0;
    logic [7:0]  last_out  = '0;
    bit          acc       = 1'b0;

    // Memory contents: the cold-miss line carries fixed words, everything
    // else an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [13:0] wa);
        case (wa)
            14'h048C: return 32'hA0A1A2A3;
            14'h048D: return 32'hB0B1B2B3;
            14'h048E: return 32'hC0C1C2C3;
            14'h048F: return 32'hD0D1D2D3;
            default:  return {2'b10, wa, ~wa[7:0], wa[7:0]};
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        logic [31:0] w;
        w = mem_word(a[15:2]);
        case (a[1:0])
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    task automatic predict(input logic [15:0] a);
        logic [5:0] idx;
        logic [5:0] t;
        idx = a[9:4];
        t   = a[15:10];
        if (!(m_valid[idx] && m_tag[idx] == t)) begin
            for (int w = 0; w < 4; w++) begin
                exp_maddr.push_back({a[15:4], 2'(w)});
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // Negedge half of a cycle: the memory responder.
    task automatic step();
        @(negedge clk);
        ncyc++;
        if (memory_stb && stb_prev && !memory_ack) begin
            n_checks++;
            if (memory_addr !== addr_prev) begin
                n_fail++;
                $display("FAIL addr_stable: memory_addr=%h required %h", memory_addr, addr_prev);
            end
        end
        stb_prev   = memory_stb;
        addr_prev  = memory_addr;
        memory_ack = 1'b0;
        if (memory_stb && ack_count != ack_stop) begin
            skip = gap_mode ? ~skip : 1'b0;
            if (!skip) begin
                n_checks++;
                if (exp_maddr.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_stb: memory_addr=%h required no request", memory_addr);
                end else begin
                    logic [13:0] e;
                    e = exp_maddr.pop_front();
                    if (memory_addr !== e) begin
                        n_fail++;
                        $display("FAIL memory_addr: got %h required %h", memory_addr, e);
                    end
                end
                memory_ack  = 1'b1;
                memory_data = mem_word(memory_addr);
                ack_count++;
            end
        end
    endtask

    // After inputs are driven: consumer scoreboard and lookup acceptance.
    task automatic observe();
        #1;
        if (!rst && cache_valid_out && cache_ready_in) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %h required none", cache_data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (cache_data_out !== e) begin
                    n_fail++;
                    $display("FAIL data_out: got %h required %h", cache_data_out, e);
                end
            end
            last_out = cache_data_out;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        acc = !rst && cache_valid_in && cache_ready_out;
        if (acc) begin
            exp_q.push_back(exp_byte(cache_addr_in));
            predict(cache_addr_in);
        end
    endtask

    task automatic cyc(input logic vin, input logic [15:0] a, input logic rin);
        step();
        cache_valid_in = vin;
        cache_addr_in  = a;
        cache_ready_in = rin;
        observe();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic fetch(input logic [15:0] a);
        int k;
        k = 0;
        cyc(1'b1, a, 1'b1);
        while (!acc && k < 300) begin
            cyc(1'b1, a, 1'b1);
            k++;
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL fetch_timeout: addr %h accepted=0 required 1", a);
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp_maddr.size() != 0) && k < budget) begin
            idle(1);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0 || exp_maddr.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending bytes=%0d words=%0d required 0 0",
                     exp_q.size(), exp_maddr.size());
        end
    endtask

    task automatic release_and_sweep();
        int  zeros;
        bit  stb_seen;
        step();
        rst            = 1'b0;
        cache_valid_in = 1'b0;
        cache_ready_in = 1'b1;
        observe();
        zeros    = 0;
        stb_seen = 1'b0;
        while (!cache_ready_out && zeros < 300) begin
            if (memory_stb) stb_seen = 1'b1;
            zeros++;
            idle(1);
        end
        n_checks++;
        if (zeros != 64) begin
            n_fail++;
            $display("FAIL sweep_length: ready low for %0d cycles required 64", zeros);
        end
        n_checks++;
        if (stb_seen) begin
            n_fail++;
            $display("FAIL sweep_stb: memory_stb=1 during sweep required 0");
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        cache_valid_in = 1'b0;
        cache_addr_in  = '0;
        cache_ready_in = 1'b1;
        memory_ack     = 1'b0;
        memory_data    = '0;
`ifdef ICACHE_FLUSH_EN
        flush          = 1'b0;
`endif
        model_clear();
        idle(3);
        n_checks++;
        if ({cache_ready_out, cache_valid_out, memory_stb} !== 3'b000 || memory_addr !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/vld/stb=%b addr=%h required 000 0000",
                     {cache_ready_out, cache_valid_out, memory_stb}, memory_addr);
        end
        release_and_sweep();
    endtask

    task automatic test_cold_miss();
        int a0;
        a0 = ack_count;
        fetch(16'h1234);
        drain(200);
        n_checks++;
        if (ack_count - a0 != 4) begin
            n_fail++;
            $display("FAIL cold_miss_acks: got %0d required 4", ack_count - a0);
        end
        // word 1 = B0B1B2B3, byte offset 0 is the most significant byte
        n_checks++;
        if (last_out !== 8'hB0) begin
            n_fail++;
            $display("FAIL cold_miss_byte: got %h required b0", last_out);
        end
    endtask

    task automatic test_hit_stream();
        int a0;
        int c0;
        a0      = ack_count;
        c0      = ncyc;
        max_run = 0;
        for (int i = 0; i < 16; i++) fetch(16'h1230 + 16'(i));
        n_checks++;
        if (ncyc - c0 != 16) begin
            n_fail++;
            $display("FAIL stream_accept: 16 lookups took %0d cycles required 16", ncyc - c0);
        end
        drain(50);
        n_checks++;
        if (max_run != 16) begin
            n_fail++;
            $display("FAIL stream_output: longest byte run %0d required 16", max_run);
        end
        n_checks++;
        if (ack_count != a0) begin
            n_fail++;
            $display("FAIL stream_memory: %0d acks required 0", ack_count - a0);
        end
    endtask

    task automatic test_conflict();
        int a0;
        a0       = ack_count;
        gap_mode = 1'b1;
        fetch(16'h5234);
        fetch(16'h1234);
        drain(400);
        gap_mode = 1'b0;
        n_checks++;
        if (ack_count - a0 != 8) begin
            n_fail++;
            $display("FAIL conflict_acks: got %0d required 8", ack_count - a0);
        end
    endtask

    task automatic test_backpressure();
        int a0;
        a0 = ack_count;
        fetch(16'h1235);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'h1236, 1'b0);
            n_checks++;
            if (cache_valid_out !== 1'b1 || cache_ready_out !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_handshake: vld=%b rdy=%b required 1 0",
                         cache_valid_out, cache_ready_out);
            end
            n_checks++;
            if (exp_q.size() == 0 || cache_data_out !== exp_q[0]) begin
                n_fail++;
                $display("FAIL stall_data: got %h required %h", cache_data_out, exp_byte(16'h1235));
            end
        end
        fetch(16'h1236);
        drain(50);
        n_checks++;
        if (ack_count != a0) begin
            n_fail++;
            $display("FAIL stall_memory: %0d acks required 0", ack_count - a0);
        end
    endtask

    task automatic test_reset_mid_fill();
        int a0;
        int k;
        ack_stop = ack_count + 2;
        fetch(16'h0340);
        k = 0;
        while (ack_count < ack_stop && k < 100) begin
            idle(1);
            k++;
        end
        n_checks++;
        if (ack_count != ack_stop) begin
            n_fail++;
            $display("FAIL midfill_acks: got %0d required %0d", ack_count, ack_stop);
        end
        idle(1);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cache_ready_out, cache_valid_out, memory_stb} !== 3'b000 || memory_addr !== 14'h0) begin
            n_fail++;
            $display("FAIL midfill_reset: rdy/vld/stb=%b addr=%h required 000 0000",
                     {cache_ready_out, cache_valid_out, memory_stb}, memory_addr);
        end
        exp_q.delete();
        exp_maddr.delete();
        model_clear();
        idle(2);
        ack_stop = -1;
        release_and_sweep();
        a0 = ack_count;
        fetch(16'h0340);
        drain(200);
        n_checks++;
        if (ack_count - a0 != 4) begin
            n_fail++;
            $display("FAIL midfill_refetch: %0d acks required 4", ack_count - a0);
        end
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush();
        int a0;
        int k;
        int zeros;
        fetch(16'h7780);
        k = 0;
        while (!memory_stb && k < 50) begin
            idle(1);
            k++;
        end
        n_checks++;
        if (!memory_stb) begin
            n_fail++;
            $display("FAIL flush_fill_start: memory_stb=0 required 1");
        end
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        drain(200);
        // delivery cycle, one RUN cycle that launches the sweep, then 64 lines
        zeros = 0;
        while (!cache_ready_out && zeros < 300) begin
            zeros++;
            idle(1);
        end
        n_checks++;
        if (zeros != 66) begin
            n_fail++;
            $display("FAIL flush_sweep: ready low for %0d cycles required 66", zeros);
        end
        model_clear();
        a0 = ack_count;
        fetch(16'h0340);
        drain(200);
        n_checks++;
        if (ack_count - a0 != 4) begin
            n_fail++;
            $display("FAIL flush_refetch: %0d acks required 4", ack_count - a0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_conflict();
        test_backpressure();
        test_reset_mid_fill();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
